button_event_arbiter: RTL and testbench

- Collects single-cycle press pulses from N_REQ button channels, each already debounced and single-pulsed upstream.
- Latches each press as a pending request and grants channels round-robin.
- Presents one event ID at a time to a shared downstream consumer over a valid/ready handshake.
- Guarantees no press is silently lost: a press arriving while the same channel is still pending sets a sticky overflow flag.

---
 rtl/button_event_arbiter.sv | 131 +++++++++++++
 tb/tb_button_event_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns per-channel press pulses into a stream of event IDs for
// one shared consumer.
//
// Each press is latched as a pending bit. Pending channels are granted in round-robin order
// and offered one at a time over a valid/ready handshake. A press on a channel that is
// still pending sets a sticky overflow flag for that channel, so no press is lost unnoticed.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req_pulse  one-cycle press pulses, one bit per channel
//   evt_valid  event offered to the consumer
//   evt_id     channel index of the offered event, stable while evt_valid is high
//   evt_ready  consumer accepts when evt_valid && evt_ready
//   pending    registered pending-request bits
//   overflow   sticky per-channel lost-press flags
//   ovf_clr    per-bit clear strobe for overflow; a simultaneous new overflow wins
module button_event_arbiter #(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned IDW        = 2,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_pulse,
   output logic             evt_valid,
   output logic [IDW-1:0]   evt_id,
   input  logic             evt_ready,
   output logic [N_REQ-1:0] pending,
   output logic [N_REQ-1:0] overflow,
   input  logic [N_REQ-1:0] ovf_clr
);

   typedef enum logic [1:0] {StIdle, StOffer, StGap} state_e;

   localparam logic [7:0]     GapInit  = 8'(GAP_CYCLES);
   localparam logic [IDW-1:0] LastInit = IDW'(N_REQ - 1);

   state_e           state_q;
   logic             evt_valid_q;
   logic [IDW-1:0]   evt_id_q;
   logic [IDW-1:0]   last_grant_q;
   logic [7:0]       gap_cnt_q;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [N_REQ-1:0] overflow_q, overflow_d;
   logic [N_REQ-1:0] clr_hit;
   logic             accept;
   logic             pick_found;
   logic [IDW-1:0]   pick_idx;
   logic [IDW-1:0]   scan_idx;

   assign accept = evt_valid_q & evt_ready;

   // A new press beats the clear from its own accept, so a press in the accept cycle
   // re-arms the channel instead of being counted as lost.
   always_comb begin
      clr_hit = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         clr_hit[i] = accept && (evt_id_q == IDW'(i));
      end
      pending_d  = req_pulse | (pending_q & ~clr_hit);
      overflow_d = (req_pulse & pending_q & ~clr_hit) | (overflow_q & ~ovf_clr);
   end

   // Scan starts just after the last granted channel; the modulo keeps indices below
   // N_REQ when it is not a power of two.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         scan_idx = IDW'((32'(last_grant_q) + k) % N_REQ);
         if (!pick_found && pending_q[scan_idx]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         evt_valid_q  <= 1'b0;
         evt_id_q     <= '0;
         last_grant_q <= LastInit;
         gap_cnt_q    <= '0;
         pending_q    <= '0;
         overflow_q   <= '0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         case (state_q)
            StIdle: begin
               if (pick_found) begin
                  evt_id_q    <= pick_idx;
                  evt_valid_q <= 1'b1;
                  state_q     <= StOffer;
               end
            end
            StOffer: begin
               if (accept) begin
                  evt_valid_q  <= 1'b0;
                  last_grant_q <= evt_id_q;
                  // The IDLE arbitration cycle is itself an idle cycle, so a gap of 0 or 1
                  // needs no extra GAP cycles.
                  if (GAP_CYCLES > 1) begin
                     gap_cnt_q <= GapInit;
                     state_q   <= StGap;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StGap: begin
               // Leave once the decremented count reaches 1.
               gap_cnt_q <= gap_cnt_q - 8'd1;
               if (gap_cnt_q <= 8'd2) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign evt_valid = evt_valid_q;
   assign evt_id    = evt_id_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance, no gap
   logic       rst_n;
   logic [3:0] req_pulse;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_ready;
   logic [3:0] pending;
   logic [3:0] overflow;
   logic [3:0] ovf_clr;

   // Second instance with a 3-cycle gap
   logic       rst_n_g;
   logic [3:0] req_g;
   logic       valid_g;
   logic [1:0] id_g;
   logic       rdy_g;
   logic [3:0] pend_g;
   logic [3:0] ovf_g;
   logic [3:0] clr_g;

   button_event_arbiter #(.N_REQ(4), .IDW(2), .GAP_CYCLES(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_pulse (req_pulse),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .pending   (pending),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   button_event_arbiter #(.N_REQ(4), .IDW(2), .GAP_CYCLES(3)) dut_gap (
      .clk       (clk),
      .rst_n     (rst_n_g),
      .req_pulse (req_g),
      .evt_valid (valid_g),
      .evt_id    (id_g),
      .evt_ready (rdy_g),
      .pending   (pend_g),
      .overflow  (ovf_g),
      .ovf_clr   (clr_g)
   );

   int          tests = 0;
   int          fails = 0;
   logic [1:0]  sb[$];
   logic [31:0] mon_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input logic [3:0] r);
      req_pulse = r;
      tick();
      req_pulse = 4'b0000;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   // Every accepted event must match the next expected ID; an accept with nothing
   // expected compares against X and fails.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
         mon_exp = 'x;
         if (sb.size() != 0) mon_exp = 32'(sb.pop_front());
         check("accepted_evt_id", 32'(evt_id), mon_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1);
   end

   initial begin
      int stable;
      int gap_n;

      // Reset with presses asserted
      rst_n = 1'b0; req_pulse = 4'b1111; evt_ready = 1'b1; ovf_clr = 4'b0000;
      rst_n_g = 1'b0; req_g = 4'b0000; rdy_g = 1'b1; clr_g = 4'b0000;
      ticks(2);
      check("rst_valid", 32'(evt_valid), 32'd0);
      check("rst_id", 32'(evt_id), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_gap_valid", 32'(valid_g), 32'd0);
      rst_n = 1'b1; req_pulse = 4'b0000; rst_n_g = 1'b1;
      tick();
      check("rst_drops_presses", 32'(pending), 32'd0);

      // Round-robin from reset: channel 0 first, then wrap from 3 to 0
      sb.push_back(2'd0); sb.push_back(2'd1); sb.push_back(2'd2); sb.push_back(2'd3);
      pulse(4'b1111);
      tick();
      check("first_grant_valid", 32'(evt_valid), 32'd1);
      check("first_grant_id", 32'(evt_id), 32'd0);
      drain("rr_all_drain");
      sb.push_back(2'd0); sb.push_back(2'd1);
      pulse(4'b0011);
      drain("rr_wrap_drain");
      ticks(2);

      // Single press latency: pending at t+1, valid at t+2, gone at t+3
      sb.push_back(2'd2);
      pulse(4'b0100);
      check("single_pending", 32'(pending), 32'h4);
      check("single_not_yet_valid", 32'(evt_valid), 32'd0);
      tick();
      check("single_valid", 32'(evt_valid), 32'd1);
      check("single_id", 32'(evt_id), 32'd2);
      tick();
      check("single_valid_drop", 32'(evt_valid), 32'd0);
      check("single_pending_clr", 32'(pending), 32'd0);

      // Backpressure: last grant was 2, so 3 first; ch0 arrives during OFFER and
      // outranks ch1 without disturbing the offered ID
      evt_ready = 1'b0;
      sb.push_back(2'd3); sb.push_back(2'd0); sb.push_back(2'd1);
      pulse(4'b1010);
      tick();
      stable = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) req_pulse = 4'b0001;
         else if (i == 10) req_pulse = 4'b1010;
         else req_pulse = 4'b0000;
         tick();
         if (evt_valid === 1'b1 && evt_id === 2'd3) stable++;
      end
      req_pulse = 4'b0000;
      check("bp_stable_cycles", 32'(stable), 32'd20);
      check("bp_pending", 32'(pending), 32'hB);
      check("bp_overflow", 32'(overflow), 32'hA);
      evt_ready = 1'b1;
      drain("bp_drain");
      ovf_clr = 4'b1111;
      tick();
      ovf_clr = 4'b0000;
      check("bp_ovf_cleared", 32'(overflow), 32'd0);

      // Double press while pending: overflow, one event only
      evt_ready = 1'b0;
      sb.push_back(2'd1);
      pulse(4'b0010);
      pulse(4'b0010);
      check("ovf_set", 32'(overflow), 32'h2);
      check("ovf_pending", 32'(pending), 32'h2);
      evt_ready = 1'b1;
      drain("ovf_drain");
      ticks(3);
      check("ovf_single_event", 32'(pending), 32'd0);

      // Press in the accept cycle: pending stays, overflow unchanged, second event
      evt_ready = 1'b0;
      sb.push_back(2'd1);
      pulse(4'b0010);
      tick();
      evt_ready = 1'b1;
      req_pulse = 4'b0010;
      sb.push_back(2'd1);
      tick();
      req_pulse = 4'b0000;
      check("setwin_pending", 32'(pending), 32'h2);
      check("setwin_overflow", 32'(overflow), 32'h2);
      drain("setwin_drain");

      // Clear alone works; clear together with a new overflow loses
      ovf_clr = 4'b0010;
      tick();
      ovf_clr = 4'b0000;
      check("ovf_clr_alone", 32'(overflow), 32'd0);
      evt_ready = 1'b0;
      sb.push_back(2'd1);
      pulse(4'b0010);
      req_pulse = 4'b0010;
      ovf_clr = 4'b0010;
      tick();
      req_pulse = 4'b0000;
      ovf_clr = 4'b0000;
      check("ovf_set_beats_clr", 32'(overflow), 32'h2);
      evt_ready = 1'b1;
      drain("ovf_clr_drain");

      // Gap instance: exactly 3 idle cycles between accepts
      req_g = 4'b0101;
      tick();
      req_g = 4'b0000;
      tick();
      check("gap_first_valid", 32'(valid_g), 32'd1);
      check("gap_first_id", 32'(id_g), 32'd0);
      gap_n = 0;
      do begin
         tick();
         if (valid_g !== 1'b1) gap_n++;
      end while (valid_g !== 1'b1 && gap_n < 20);
      check("gap_idle_cycles", 32'(gap_n), 32'd3);
      check("gap_second_id", 32'(id_g), 32'd2);
      req_g = 4'b0010;
      tick();
      req_g = 4'b0000;
      check("gap_in_gap_valid", 32'(valid_g), 32'd0);
      check("gap_in_gap_pending", 32'(pend_g), 32'h2);
      rst_n_g = 1'b0;
      tick();
      check("gap_rst_pending", 32'(pend_g), 32'd0);
      check("gap_rst_valid", 32'(valid_g), 32'd0);
      rst_n_g = 1'b1;
      req_g = 4'b1000;
      tick();
      req_g = 4'b0000;
      tick();
      check("gap_rst_idle_valid", 32'(valid_g), 32'd1);
      check("gap_rst_idle_id", 32'(id_g), 32'd3);
      ticks(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
